// File: rtl/peak_readout_bank_if.sv
// Host register bus for peak_readout_bank: byte-wide strobed read/write port.
interface peak_readout_bank_if;
   logic       chipselect;
   logic       read;
   logic       write;
   logic [7:0] address;
   logic [7:0] writedata;
   logic [7:0] readdata;

   modport master (output chipselect, read, write, address, writedata, input readdata);
   modport slave  (input chipselect, read, write, address, writedata, output readdata);
endinterface

// File: rtl/peak_readout_bank.sv
// Double-banked peak frame readout: frames land in a visible bank while open,
// or in a staging bank while the host holds the lock; unlock commits staging.
module peak_readout_bank #(
   parameter int unsigned PEAKS      = 6,
   parameter int unsigned FREQ_WIDTH = 8,
   parameter int unsigned AMPL_WIDTH = 24,
   parameter int unsigned TIME_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        valid_in,
   input  logic [TIME_WIDTH-1:0]       counter_in,
   input  logic [PEAKS*FREQ_WIDTH-1:0] freqs_in,
   input  logic [PEAKS*AMPL_WIDTH-1:0] ampls_in,
   peak_readout_bank_if.slave          bus,
   output logic                        irq
);
   localparam int unsigned AB        = AMPL_WIDTH / 8;
   localparam int unsigned TB        = TIME_WIDTH / 8;
   localparam int unsigned MAP_BYTES = TB + PEAKS + PEAKS * AB;
   localparam logic [7:0]  ADDR_CTRL = 8'hF0;
   localparam logic [7:0]  ADDR_STAT = 8'hF1;
   localparam logic [7:0]  ADDR_OVF  = 8'hF2;
   localparam logic [7:0]  ADDR_SEQ  = 8'hF3;
   localparam logic [7:0]  ADDR_ID   = 8'hFF;

   if (MAP_BYTES > 240) begin : g_map_chk
      $error("peak_readout_bank: bank map overlaps control registers");
   end

   typedef enum logic [1:0] {ST_OPEN, ST_LOCKED, ST_COMMIT} state_e;

   state_e                        state_q, state_d;
   logic [TIME_WIDTH-1:0]         vis_cnt_q, vis_cnt_d, stg_cnt_q, stg_cnt_d;
   logic [PEAKS*FREQ_WIDTH-1:0]   vis_frq_q, vis_frq_d, stg_frq_q, stg_frq_d;
   logic [PEAKS*AMPL_WIDTH-1:0]   vis_amp_q, vis_amp_d, stg_amp_q, stg_amp_d;
   logic [1:0]                    ctrl_q, ctrl_d;
   logic                          pending_q, pending_d;
   logic                          fresh_q, fresh_d;
   logic [7:0]                    ovf_q, ovf_d;
   logic [7:0]                    seq_q, seq_d;
   logic                          irq_q, irq_d;
   logic [7:0]                    readdata_q, readdata_d;
   logic [7:0]                    rd_c;
   logic                          wr_en_c, fresh_set_c, ovf_inc_c;
   logic                          unused_wdata;

   assign wr_en_c      = bus.chipselect & bus.write;
   assign unused_wdata = ^bus.writedata[7:2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_OPEN;
         vis_cnt_q  <= '0;
         vis_frq_q  <= '0;
         vis_amp_q  <= '0;
         stg_cnt_q  <= '0;
         stg_frq_q  <= '0;
         stg_amp_q  <= '0;
         ctrl_q     <= '0;
         pending_q  <= 1'b0;
         fresh_q    <= 1'b0;
         ovf_q      <= '0;
         seq_q      <= '0;
         irq_q      <= 1'b0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         vis_cnt_q  <= vis_cnt_d;
         vis_frq_q  <= vis_frq_d;
         vis_amp_q  <= vis_amp_d;
         stg_cnt_q  <= stg_cnt_d;
         stg_frq_q  <= stg_frq_d;
         stg_amp_q  <= stg_amp_d;
         ctrl_q     <= ctrl_d;
         pending_q  <= pending_d;
         fresh_q    <= fresh_d;
         ovf_q      <= ovf_d;
         seq_q      <= seq_d;
         irq_q      <= irq_d;
         readdata_q <= readdata_d;
      end
   end

   // Next state, bank transfers and status bookkeeping.
   always_comb begin
      state_d     = state_q;
      vis_cnt_d   = vis_cnt_q;
      vis_frq_d   = vis_frq_q;
      vis_amp_d   = vis_amp_q;
      stg_cnt_d   = stg_cnt_q;
      stg_frq_d   = stg_frq_q;
      stg_amp_d   = stg_amp_q;
      ctrl_d      = ctrl_q;
      pending_d   = pending_q;
      ovf_d       = ovf_q;
      seq_d       = seq_q;
      fresh_set_c = 1'b0;
      ovf_inc_c   = 1'b0;
      readdata_d  = readdata_q;

      if (wr_en_c && bus.address == ADDR_CTRL) ctrl_d = bus.writedata[1:0];

      case (state_q)
         ST_OPEN: begin
            if (valid_in) begin
               vis_cnt_d   = counter_in;
               vis_frq_d   = freqs_in;
               vis_amp_d   = ampls_in;
               fresh_set_c = 1'b1;
               seq_d       = seq_q + 8'd1;
            end
            if (ctrl_d[0]) state_d = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (valid_in) begin
               stg_cnt_d = counter_in;
               stg_frq_d = freqs_in;
               stg_amp_d = ampls_in;
               ovf_inc_c = pending_q;
               pending_d = 1'b1;
            end
            if (!ctrl_d[0]) state_d = pending_d ? ST_COMMIT : ST_OPEN;
         end
         ST_COMMIT: begin
            vis_cnt_d   = stg_cnt_q;
            vis_frq_d   = stg_frq_q;
            vis_amp_d   = stg_amp_q;
            fresh_set_c = 1'b1;
            seq_d       = seq_q + 8'd1;
            pending_d   = 1'b0;
            // A frame arriving mid-commit is staged and committed on the next edge.
            if (valid_in) begin
               stg_cnt_d = counter_in;
               stg_frq_d = freqs_in;
               stg_amp_d = ampls_in;
               pending_d = 1'b1;
            end else begin
               state_d = ctrl_d[0] ? ST_LOCKED : ST_OPEN;
            end
         end
         default: state_d = ST_OPEN;
      endcase

      fresh_d = fresh_set_c |
                (fresh_q & ~(wr_en_c && bus.address == ADDR_STAT && bus.writedata[1]));

      if (wr_en_c && bus.address == ADDR_OVF) ovf_d = ovf_inc_c ? 8'd1 : 8'd0;
      else if (ovf_inc_c && ovf_q != 8'hFF)   ovf_d = ovf_q + 8'd1;

      irq_d = ctrl_d[1] & fresh_d;
      if (bus.chipselect && bus.read) readdata_d = rd_c;
   end

   // Read decode of the visible bank and control registers.
   always_comb begin
      rd_c = 8'h00;
      for (int k = 0; k < int'(TB); k++)
         if (bus.address == 8'(k)) rd_c = vis_cnt_q[(int'(TB) - 1 - k) * 8 +: 8];
      for (int i = 0; i < int'(PEAKS); i++)
         if (bus.address == 8'(int'(TB) + i)) rd_c = 8'(vis_frq_q[i * int'(FREQ_WIDTH) +: FREQ_WIDTH]);
      for (int i = 0; i < int'(PEAKS); i++)
         for (int j = 0; j < int'(AB); j++)
            if (bus.address == 8'(int'(TB + PEAKS) + i * int'(AB) + j))
               rd_c = vis_amp_q[i * int'(AMPL_WIDTH) + (int'(AB) - 1 - j) * 8 +: 8];
      case (bus.address)
         ADDR_CTRL: rd_c = {6'd0, ctrl_q};
         ADDR_STAT: rd_c = {6'd0, fresh_q, pending_q};
         ADDR_OVF:  rd_c = ovf_q;
         ADDR_SEQ:  rd_c = seq_q;
         ADDR_ID:   rd_c = 8'h5A;
         default:   ;
      endcase
   end

   assign bus.readdata = readdata_q;
   assign irq          = irq_q;
endmodule

// File: tb/tb_peak_readout_bank.sv
// Directed bench for peak_readout_bank: read-map table plus lock/commit/reset sequences.
module tb_peak_readout_bank;
   localparam int unsigned PEAKS = 6, FW = 8, AW = 24, TW = 32;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  valid_in = 1'b0;
   logic [TW-1:0]         counter_in = '0;
   logic [PEAKS*FW-1:0]   freqs_in = '0;
   logic [PEAKS*AW-1:0]   ampls_in = '0;
   logic                  irq;
   int                    checks = 0;
   int                    errors = 0;

   typedef struct { logic [7:0] addr; logic [7:0] exp; } rvec_t;
   rvec_t tbl[23];

   peak_readout_bank_if bus();

   peak_readout_bank #(.PEAKS(PEAKS), .FREQ_WIDTH(FW), .AMPL_WIDTH(AW), .TIME_WIDTH(TW)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .counter_in(counter_in),
      .freqs_in(freqs_in), .ampls_in(ampls_in), .bus(bus), .irq(irq));

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
      logic [7:0] d;
      @(negedge clk);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
      @(negedge clk);
      d = bus.readdata;
      bus.chipselect = 1'b0; bus.read = 1'b0;
      check($sformatf("%s[%02h]", name, a), 32'(d), 32'(exp));
   endtask

   // One cycle with an optional register write and an optional frame pulse.
   task automatic step(input bit w, input logic [7:0] a, input logic [7:0] d,
                       input bit v, input logic [31:0] cnt);
      @(negedge clk);
      bus.chipselect = w; bus.write = w; bus.address = a; bus.writedata = d;
      valid_in = v; counter_in = cnt;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write = 1'b0; valid_in = 1'b0;
   endtask

   initial begin
      logic [7:0] held;
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.address = 8'h00; bus.writedata = 8'h00;
      freqs_in = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      ampls_in = {24'h0F0E0D, 24'h0C0B0A, 24'h090807, 24'h060504, 24'h123456, 24'hAABBCC};

      tbl[0]  = '{8'h00, 8'h01}; tbl[1]  = '{8'h01, 8'h02}; tbl[2]  = '{8'h02, 8'h03};
      tbl[3]  = '{8'h03, 8'h04}; tbl[4]  = '{8'h04, 8'h11}; tbl[5]  = '{8'h05, 8'h22};
      tbl[6]  = '{8'h09, 8'h66}; tbl[7]  = '{8'h0A, 8'hAA}; tbl[8]  = '{8'h0B, 8'hBB};
      tbl[9]  = '{8'h0C, 8'hCC}; tbl[10] = '{8'h0D, 8'h12}; tbl[11] = '{8'h0E, 8'h34};
      tbl[12] = '{8'h0F, 8'h56}; tbl[13] = '{8'h19, 8'h0F}; tbl[14] = '{8'h1A, 8'h0E};
      tbl[15] = '{8'h1B, 8'h0D}; tbl[16] = '{8'h1C, 8'h00}; tbl[17] = '{8'hF0, 8'h00};
      tbl[18] = '{8'hF1, 8'h02}; tbl[19] = '{8'hF2, 8'h00}; tbl[20] = '{8'hF3, 8'h01};
      tbl[21] = '{8'hFF, 8'h5A}; tbl[22] = '{8'hE0, 8'h00};

      repeat (3) @(negedge clk);
      check("reset_irq", 32'(irq), 32'd0);
      check("reset_readdata", 32'(bus.readdata), 32'd0);
      reset = 1'b1;
      rd_chk("reset_seq", 8'hF3, 8'h00);
      rd_chk("reset_cnt", 8'h03, 8'h00);

      // Open frame lands directly in the visible bank.
      step(1'b0, 8'h00, 8'h00, 1'b1, 32'h01020304);
      for (int i = 0; i < 23; i++) rd_chk("map", tbl[i].addr, tbl[i].exp);
      check("irq_no_en", 32'(irq), 32'd0);

      // readdata holds without a read strobe.
      @(negedge clk); bus.address = 8'h00;
      @(negedge clk); held = bus.readdata;
      check("readdata_hold", 32'(held), 32'h00);

      // Lock, two frames, overflow, then commit on unlock.
      step(1'b1, 8'hF1, 8'h02, 1'b0, 32'd0);
      rd_chk("fresh_w1c", 8'hF1, 8'h00);
      step(1'b1, 8'hF0, 8'h03, 1'b0, 32'd0);
      check("irq_after_clear", 32'(irq), 32'd0);
      step(1'b0, 8'h00, 8'h00, 1'b1, 32'd5);
      step(1'b0, 8'h00, 8'h00, 1'b1, 32'd6);
      rd_chk("locked_cnt", 8'h03, 8'h04);
      rd_chk("locked_stat", 8'hF1, 8'h01);
      rd_chk("locked_ovf", 8'hF2, 8'h01);
      step(1'b1, 8'hF0, 8'h02, 1'b0, 32'd0);
      rd_chk("commit_cnt", 8'h03, 8'h06);
      rd_chk("commit_stat", 8'hF1, 8'h02);
      rd_chk("commit_seq", 8'hF3, 8'h02);
      check("commit_irq", 32'(irq), 32'd1);

      // W1C colliding with an open frame keeps fresh set.
      step(1'b1, 8'hF1, 8'h02, 1'b1, 32'h00000021);
      check("w1c_collide_irq", 32'(irq), 32'd1);
      rd_chk("w1c_collide_stat", 8'hF1, 8'h02);
      rd_chk("w1c_collide_cnt", 8'h03, 8'h21);
      step(1'b1, 8'hF1, 8'h02, 1'b0, 32'd0);
      check("w1c_irq_low", 32'(irq), 32'd0);

      // Overflow clear colliding with an increment yields 1.
      step(1'b1, 8'hF0, 8'h03, 1'b0, 32'd0);
      step(1'b0, 8'h00, 8'h00, 1'b1, 32'd7);
      step(1'b1, 8'hF2, 8'h00, 1'b1, 32'd8);
      rd_chk("ovf_collide", 8'hF2, 8'h01);

      // Saturation and clear.
      for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 32'(i));
      rd_chk("ovf_sat", 8'hF2, 8'hFF);
      step(1'b1, 8'hF2, 8'h55, 1'b0, 32'd0);
      rd_chk("ovf_clr", 8'hF2, 8'h00);

      // Frame during COMMIT is staged then committed one cycle later.
      @(negedge clk);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 8'hF0; bus.writedata = 8'h02;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write = 1'b0;
      valid_in = 1'b1; counter_in = 32'h00000077;
      @(negedge clk);
      valid_in = 1'b0;
      rd_chk("commit_frame_cnt", 8'h03, 8'h77);
      rd_chk("commit_frame_seq", 8'hF3, 8'h05);
      rd_chk("commit_frame_stat", 8'hF1, 8'h02);

      // Lock write coincident with a frame: frame is treated as open.
      step(1'b1, 8'hF0, 8'h03, 1'b1, 32'h0A0B0C0D);
      rd_chk("lock_collide_cnt", 8'h00, 8'h0A);
      rd_chk("lock_collide_seq", 8'hF3, 8'h06);
      step(1'b0, 8'h00, 8'h00, 1'b1, 32'h000000EE);
      rd_chk("lock_collide_stat", 8'hF1, 8'h03);

      // Async reset mid-LOCKED with pending.
      @(negedge clk); #2 reset = 1'b0; #1;
      check("midreset_irq", 32'(irq), 32'd0);
      check("midreset_readdata", 32'(bus.readdata), 32'd0);
      @(negedge clk); reset = 1'b1;
      rd_chk("post_reset", 8'hF0, 8'h00);
      rd_chk("post_reset", 8'hF1, 8'h00);
      rd_chk("post_reset", 8'hF2, 8'h00);
      rd_chk("post_reset", 8'hF3, 8'h00);
      rd_chk("post_reset", 8'h03, 8'h00);
      step(1'b0, 8'h00, 8'h00, 1'b1, 32'h000000C3);
      rd_chk("post_reset_frame", 8'h03, 8'hC3);
      rd_chk("post_reset_seq", 8'hF3, 8'h01);

      // Unlock with nothing pending returns straight to OPEN.
      step(1'b1, 8'hF0, 8'h01, 1'b0, 32'd0);
      step(1'b1, 8'hF0, 8'h00, 1'b0, 32'd0);
      rd_chk("nopend_seq", 8'hF3, 8'h01);
      step(1'b0, 8'h00, 8'h00, 1'b1, 32'h000000D4);
      rd_chk("nopend_frame", 8'h03, 8'hD4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
